// File: rtl/smc_clk_enable_gen.sv
// smc_clk_enable_gen: multi-channel clock-enable / divided-level generator.
// Each channel has a shadow (div, phase) pair that cfg_apply copies to the
// active pair for every channel at once. The apply edge also zeroes every
// counter so that all channels restart phase-aligned.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_SETTLE  | channels realigned recently; settle counter running, locked=0
// ST_LOCKED  | settle window elapsed; locked=1 until next apply or reset
module smc_clk_enable_gen #(
    parameter int NUM_CLOCKS  = 4,
    parameter int DIV_WIDTH   = 16,
    parameter int DEFAULT_DIV = 2,
    parameter int LOCK_CYCLES = 16
) (
    input  logic                  refclk,
    input  logic                  rst,
    input  logic                  cfg_wr,
    input  logic [2:0]            cfg_ch,
    input  logic [DIV_WIDTH-1:0]  cfg_div,
    input  logic [DIV_WIDTH-1:0]  cfg_phase,
    input  logic                  cfg_apply,
    output logic [NUM_CLOCKS-1:0] outclk_en,
    output logic [NUM_CLOCKS-1:0] outclk_lvl,
    output logic                  locked
);

    localparam int SW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [SW-1:0]        SETTLE_LAST = SW'(LOCK_CYCLES - 1);
    localparam logic [DIV_WIDTH-1:0] DIV_RST     = DIV_WIDTH'(DEFAULT_DIV);
    localparam logic [DIV_WIDTH-1:0] ONE         = DIV_WIDTH'(1);

    typedef enum logic {ST_SETTLE, ST_LOCKED} state_t;

    state_t                  state_q, state_d;
    logic [SW-1:0]           settle_q, settle_d;
    logic                    locked_q, locked_d;
    logic [NUM_CLOCKS-1:0]   en_q, en_d;
    logic [NUM_CLOCKS-1:0]   lvl_q, lvl_d;

    logic [DIV_WIDTH-1:0]    sh_div_q    [NUM_CLOCKS];
    logic [DIV_WIDTH-1:0]    sh_div_d    [NUM_CLOCKS];
    logic [DIV_WIDTH-1:0]    sh_phase_q  [NUM_CLOCKS];
    logic [DIV_WIDTH-1:0]    sh_phase_d  [NUM_CLOCKS];
    logic [DIV_WIDTH-1:0]    act_div_q   [NUM_CLOCKS];
    logic [DIV_WIDTH-1:0]    act_div_d   [NUM_CLOCKS];
    logic [DIV_WIDTH-1:0]    act_phase_q [NUM_CLOCKS];
    logic [DIV_WIDTH-1:0]    act_phase_d [NUM_CLOCKS];
    logic [DIV_WIDTH-1:0]    cnt_q       [NUM_CLOCKS];
    logic [DIV_WIDTH-1:0]    cnt_d       [NUM_CLOCKS];

    logic [DIV_WIDTH-1:0]    d_eff       [NUM_CLOCKS];
    logic [DIV_WIDTH-1:0]    p_eff       [NUM_CLOCKS];
    logic [DIV_WIDTH:0]      half        [NUM_CLOCKS];

    // Effective ratio (0 -> 1), phase clamped into the period, high-time length.
    always_comb begin
        for (int i = 0; i < NUM_CLOCKS; i++) begin
            d_eff[i] = (act_div_q[i] == '0) ? ONE : act_div_q[i];
            p_eff[i] = (act_phase_q[i] > (d_eff[i] - ONE)) ? (d_eff[i] - ONE) : act_phase_q[i];
            half[i]  = ({1'b0, d_eff[i]} + (DIV_WIDTH+1)'(1)) >> 1;
        end
    end

    // Shadow writes, and write-through copy of shadow into active on apply.
    always_comb begin
        for (int i = 0; i < NUM_CLOCKS; i++) begin
            sh_div_d[i]    = sh_div_q[i];
            sh_phase_d[i]  = sh_phase_q[i];
            if (cfg_wr && (cfg_ch == 3'(i))) begin
                sh_div_d[i]   = cfg_div;
                sh_phase_d[i] = cfg_phase;
            end
            act_div_d[i]   = cfg_apply ? sh_div_d[i]   : act_div_q[i];
            act_phase_d[i] = cfg_apply ? sh_phase_d[i] : act_phase_q[i];
        end
    end

    // Per-channel counters and registered enable/level outputs.
    always_comb begin
        en_d  = '0;
        lvl_d = '0;
        for (int i = 0; i < NUM_CLOCKS; i++) begin
            cnt_d[i] = '0;
            if (!cfg_apply) begin
                cnt_d[i] = (cnt_q[i] >= (d_eff[i] - ONE)) ? '0 : (cnt_q[i] + ONE);
                en_d[i]  = (cnt_q[i] == p_eff[i]);
                lvl_d[i] = ({1'b0, cnt_q[i]} < half[i]);
            end
        end
    end

    // Settle/lock state machine; apply always restarts the settle window.
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        locked_d = locked_q;
        if (cfg_apply) begin
            state_d  = ST_SETTLE;
            settle_d = '0;
            locked_d = 1'b0;
        end else begin
            case (state_q)
                ST_SETTLE: begin
                    if (settle_q == SETTLE_LAST) begin
                        state_d  = ST_LOCKED;
                        locked_d = 1'b1;
                    end else begin
                        settle_d = settle_q + SW'(1);
                    end
                end
                ST_LOCKED: ;
                default: begin
                    state_d  = ST_SETTLE;
                    settle_d = '0;
                    locked_d = 1'b0;
                end
            endcase
        end
    end

    // State register; reset restores defaults and discards shadow edits.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_SETTLE;
            settle_q <= '0;
            locked_q <= 1'b0;
            en_q     <= '0;
            lvl_q    <= '0;
            for (int i = 0; i < NUM_CLOCKS; i++) begin
                sh_div_q[i]    <= DIV_RST;
                sh_phase_q[i]  <= '0;
                act_div_q[i]   <= DIV_RST;
                act_phase_q[i] <= '0;
                cnt_q[i]       <= '0;
            end
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            locked_q <= locked_d;
            en_q     <= en_d;
            lvl_q    <= lvl_d;
            for (int i = 0; i < NUM_CLOCKS; i++) begin
                sh_div_q[i]    <= sh_div_d[i];
                sh_phase_q[i]  <= sh_phase_d[i];
                act_div_q[i]   <= act_div_d[i];
                act_phase_q[i] <= act_phase_d[i];
                cnt_q[i]       <= cnt_d[i];
            end
        end
    end

    assign outclk_en  = en_q;
    assign outclk_lvl = lvl_q;
    assign locked     = locked_q;

endmodule

// File: tb/tb_smc_clk_enable_gen.sv
// Bench for smc_clk_enable_gen: directed steps plus random config traffic,
// checked every cycle against a model based on edges-since-alignment.
module tb_smc_clk_enable_gen;

    localparam int NUM  = 4;
    localparam int DW   = 16;
    localparam int DDIV = 2;
    localparam int LOCK = 16;

    logic            refclk = 1'b0;
    logic            rst;
    logic            cfg_wr;
    logic [2:0]      cfg_ch;
    logic [DW-1:0]   cfg_div;
    logic [DW-1:0]   cfg_phase;
    logic            cfg_apply;
    logic [NUM-1:0]  outclk_en;
    logic [NUM-1:0]  outclk_lvl;
    logic            locked;

    int errors = 0;
    int checks = 0;

    // Model: shadow/active settings and edge count since last reset/apply.
    int m_sh_div  [NUM];
    int m_sh_ph   [NUM];
    int m_act_div [NUM];
    int m_act_ph  [NUM];
    int m_k;

    smc_clk_enable_gen #(
        .NUM_CLOCKS (NUM),
        .DIV_WIDTH  (DW),
        .DEFAULT_DIV(DDIV),
        .LOCK_CYCLES(LOCK)
    ) dut (
        .refclk    (refclk),
        .rst       (rst),
        .cfg_wr    (cfg_wr),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_phase (cfg_phase),
        .cfg_apply (cfg_apply),
        .outclk_en (outclk_en),
        .outclk_lvl(outclk_lvl),
        .locked    (locked)
    );

    always #5 refclk = ~refclk;

    task automatic model_reset();
        for (int c = 0; c < NUM; c++) begin
            m_sh_div[c]  = DDIV;
            m_sh_ph[c]   = 0;
            m_act_div[c] = DDIV;
            m_act_ph[c]  = 0;
        end
        m_k = 0;
    endtask

    task automatic check_all(input string tag);
        logic [NUM-1:0] exp_en;
        logic [NUM-1:0] exp_lvl;
        logic           exp_lk;
        int d, p, pos;
        exp_en  = '0;
        exp_lvl = '0;
        exp_lk  = (m_k >= LOCK);
        if (m_k > 0) begin
            for (int c = 0; c < NUM; c++) begin
                d   = (m_act_div[c] < 1) ? 1 : m_act_div[c];
                p   = (m_act_ph[c] > d - 1) ? d - 1 : m_act_ph[c];
                pos = (m_k - 1) % d;
                exp_en[c]  = (pos == p);
                exp_lvl[c] = (pos < (d + 1) / 2);
            end
        end
        checks++;
        assert (outclk_en === exp_en) else begin
            errors++;
            $error("FAIL %s en k=%0d obs=%b exp=%b", tag, m_k, outclk_en, exp_en);
        end
        checks++;
        assert (outclk_lvl === exp_lvl) else begin
            errors++;
            $error("FAIL %s lvl k=%0d obs=%b exp=%b", tag, m_k, outclk_lvl, exp_lvl);
        end
        checks++;
        assert (locked === exp_lk) else begin
            errors++;
            $error("FAIL %s locked k=%0d obs=%b exp=%b", tag, m_k, locked, exp_lk);
        end
    endtask

    // One clock: drive inputs, advance model at the edge, check 1 time unit later.
    task automatic step(input string tag, input logic wr, input int ch,
                        input int dv, input int ph, input logic ap);
        cfg_wr    = wr;
        cfg_ch    = 3'(ch);
        cfg_div   = DW'(dv);
        cfg_phase = DW'(ph);
        cfg_apply = ap;
        @(posedge refclk);
        if (wr && ch < NUM) begin
            m_sh_div[ch] = dv;
            m_sh_ph[ch]  = ph;
        end
        if (ap) begin
            for (int c = 0; c < NUM; c++) begin
                m_act_div[c] = m_sh_div[c];
                m_act_ph[c]  = m_sh_ph[c];
            end
            m_k = 0;
        end else begin
            m_k++;
        end
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 1'b0, 0, 0, 0, 1'b0);
    endtask

    initial begin
        rst       = 1'b1;
        cfg_wr    = 1'b0;
        cfg_ch    = '0;
        cfg_div   = '0;
        cfg_phase = '0;
        cfg_apply = 1'b0;
        model_reset();
        repeat (2) @(posedge refclk);
        #2;
        rst = 1'b0;
        check_all("reset");

        idle("defaults", 20);

        step("wr_ch0", 1'b1, 0, 5, 2, 1'b0);
        step("wr_ch1", 1'b1, 1, 3, 0, 1'b0);
        step("apply1", 1'b0, 0, 0, 0, 1'b1);
        idle("div5_div3", 20);

        step("wr_ch2", 1'b1, 2, 0, 7, 1'b0);
        step("apply2", 1'b0, 0, 0, 0, 1'b1);
        idle("div0", 10);
        step("wr_ch3", 1'b1, 3, 4, 9, 1'b0);
        step("apply3", 1'b0, 0, 0, 0, 1'b1);
        idle("clamp", 20);

        step("wr_ch5", 1'b1, 5, 9, 1, 1'b0);
        step("apply4", 1'b0, 0, 0, 0, 1'b1);
        idle("ignored_ch", 20);

        step("wr_apply", 1'b1, 0, 6, 1, 1'b1);
        idle("wthrough", 10);
        step("reapply", 1'b0, 0, 0, 0, 1'b1);
        idle("settle_restart", 20);

        for (int i = 0; i < 300; i++) begin
            step("rand", ($urandom % 4) == 0, int'($urandom % 8),
                 int'($urandom % 10), int'($urandom % 12), ($urandom % 20) == 0);
        end

        step("wr_ch0_7", 1'b1, 0, 7, 0, 1'b1);
        idle("div7", 20);
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        check_all("async_rst");
        @(posedge refclk);
        #3;
        check_all("rst_held");
        rst = 1'b0;
        idle("post_rst", 24);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
